uart_apb_ctrl: RTL and testbench
================================

Name: uart_apb_ctrl

Overview:
APB3 slave that configures and sequences one uart instance: baud divisor, TX/RX enables and data transfer. Holds a 1-entry TX holding register and a 1-entry RX buffer. Drives the uart tx_enable/rx_enable handshakes and reports status/interrupt to the APB host. Sits between the APB interconnect and the uart datapath, alongside the GPIO slave.

Parameters:
ADDR_W, 5, APB address width (byte address; PADDR[1:0] ignored)
BAUD_RST, 32'd868, reset value of BAUD register

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1 = write
paddr  in  ADDR_W  byte address
pwdata  in  32  write data
prdata  out  32  read data
pready  out  1  always 1 (zero wait states)
pslverr  out  1  error response, valid in access phase
uart_data_in  out  11  byte to send; {3'b000, tx_byte}
uart_baud_select  out  32  BAUD register
uart_tx_enable  out  1  TX request to uart
uart_rx_enable  out  1  RX request to uart
uart_data_out  in  32  uart received data; [7:0] used
uart_tx_done  in  1  uart TX completion flag
uart_rx_done  in  1  uart RX completion pulse
irq  out  1  level interrupt

Behaviour:
- Reset: prdata=0, pslverr=0, uart_tx_enable=0, uart_rx_enable=0, uart_data_in=0, BAUD=BAUD_RST, CTRL=0, all flags 0, irq=0, TX FSM=T_IDLE.
- APB access commits when psel&penable; prdata/pslverr are registered and valid in that same access cycle (decode on setup phase psel&!penable).
- Register map:
  0x00 CTRL RW: [0] TX_EN, [1] RX_EN, [2] IE_TXE (irq when holding empty), [3] IE_RXV (irq when rx_valid).
  0x04 BAUD RW: 32-bit divisor. Write while tx_busy=1 -> pslverr=1, ignored. Write of 0 -> pslverr=1, ignored.
  0x08 TXDATA WO: [7:0] loads holding reg, sets tx_pend. Write with tx_pend=1 -> pslverr=1, ignored. Read -> 0.
  0x0C RXDATA RO: [7:0] rx byte; read clears rx_valid. Write -> pslverr=1.
  0x10 STATUS: [0] tx_busy, [1] tx_pend, [2] rx_valid, [3] rx_overrun (sticky, W1C); other bits RO.
  Unmapped address -> pslverr=1, prdata=0.
- TX FSM (controls uart_tx_enable):
  T_IDLE: if TX_EN & tx_pend -> latch holding byte onto uart_data_in, clear tx_pend, -> T_REQ.
  T_REQ: uart_tx_enable=1; on uart_tx_done=1 -> T_REL.
  T_REL: uart_tx_enable=0; hold 1 cycle, then wait until uart_tx_done=0 -> T_IDLE.
  tx_busy = (state != T_IDLE). Holding register may be refilled while in T_REQ/T_REL.
  TX_EN cleared mid-frame: current frame completes; no new frame starts.
- RX: uart_rx_enable = RX_EN registered. Capture on uart_rx_done rising edge (registered previous value): rx byte <= uart_data_out[7:0], rx_valid<=1; if rx_valid already 1 and not being cleared that cycle -> rx_overrun<=1 and byte overwritten.
- Same-cycle RXDATA read and capture: read returns old byte, new byte loaded, rx_valid stays 1, no overrun.
- Same-cycle TXDATA write and T_IDLE consuming the holding reg: write accepted (tx_pend stays 1 with new byte).
- irq = (IE_TXE & !tx_pend) | (IE_RXV & rx_valid), registered.
- Mid-operation rst: all state returns to reset values next cycle; uart_tx_enable drops immediately.

Decomposition:
- Package uart_apb_pkg: register offsets, CTRL/STATUS bit positions, TX FSM state enum.
- One sub-module natural: uart_apb_regs (APB decode, register file, pslverr). TX FSM and RX capture stay in top.

Test Plan:
- Reset -> read BAUD=868, CTRL=0, STATUS=0, irq=0, uart_tx_enable=0.
- CTRL=1, TXDATA=0xA5 -> uart_data_in=0x0A5, tx_enable high until tx_done, then low; STATUS.tx_busy 1 -> 0.
- Two back-to-back TXDATA writes (0x11, 0x22), third while tx_pend=1 -> third gets pslverr=1; 0x11 then 0x22 sent in order.
- RX_EN=1, uart_rx_done pulse with data_out=0x3C -> STATUS.rx_valid=1, RXDATA=0x3C, rx_valid then 0.
- Two rx_done pulses without read -> rx_overrun=1, RXDATA=second byte; write STATUS 0x8 -> overrun=0.
- BAUD write during tx_busy, BAUD=0, and paddr=0x14 -> pslverr=1 each, BAUD unchanged.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: shared definitions for the uart APB controller.
//   - byte offsets of the register map
//   - CTRL / STATUS bit positions
//   - TX sequencer state encoding
package uart_apb_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_BAUD   = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_IE_TXE = 2;
  localparam int CTRL_IE_RXV = 3;

  localparam int ST_TX_BUSY  = 0;
  localparam int ST_TX_PEND  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_REQ  = 2'd1,
    T_REL  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_apb_regs.sv
// uart_apb_regs: APB3 decode, CTRL/BAUD register file and error response.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata  APB request
//   prdata/pready/pslverr         APB response (registered on the setup phase)
//   tx_busy/tx_pend/tx_take       TX sequencer status; tx_take = holding reg consumed this cycle
//   rx_valid/rx_overrun/rx_byte   RX buffer status
//   ctrl, baud                    register contents
//   txdata_wr/txdata_byte         committed TXDATA write
//   rxdata_rd                     committed RXDATA read (clears rx_valid)
//   ovr_clr                       W1C of STATUS.rx_overrun
module uart_apb_regs
  import uart_apb_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] BAUD_RST = 32'd868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              tx_busy,
  input  logic              tx_pend,
  input  logic              tx_take,
  input  logic              rx_valid,
  input  logic              rx_overrun,
  input  logic [7:0]        rx_byte,
  output logic [3:0]        ctrl,
  output logic [31:0]       baud,
  output logic              txdata_wr,
  output logic [7:0]        txdata_byte,
  output logic              rxdata_rd,
  output logic              ovr_clr
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(OFF_CTRL);
  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(OFF_BAUD);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(OFF_TXDATA);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(OFF_RXDATA);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(OFF_STATUS);

  logic              setup, access, commit, wr_commit;
  logic [ADDR_W-1:0] addr;
  logic              sel_ctrl, sel_baud, sel_tx, sel_rx, sel_st;
  logic [31:0]       rdata;
  logic              err;
  logic              unused_paddr;

  assign unused_paddr = ^paddr[1:0];
  assign addr   = {paddr[ADDR_W-1:2], 2'b00};
  assign setup  = psel & ~penable;
  assign access = psel & penable;
  // The error decision taken on the setup phase also gates the commit.
  assign commit    = access & ~pslverr;
  assign wr_commit = commit & pwrite;
  assign pready    = 1'b1;

  assign sel_ctrl = (addr == A_CTRL);
  assign sel_baud = (addr == A_BAUD);
  assign sel_tx   = (addr == A_TXDATA);
  assign sel_rx   = (addr == A_RXDATA);
  assign sel_st   = (addr == A_STATUS);

  // A holding register being consumed this cycle counts as free for a new
  // TXDATA write, and as the start of a frame for a BAUD write.
  always_comb begin
    rdata = 32'd0;
    err   = 1'b0;
    if (sel_ctrl) begin
      rdata = {28'd0, ctrl};
    end else if (sel_baud) begin
      rdata = baud;
      err   = pwrite & (tx_busy | tx_take | (pwdata == 32'd0));
    end else if (sel_tx) begin
      err   = pwrite & tx_pend & ~tx_take;
    end else if (sel_rx) begin
      rdata = {24'd0, rx_byte};
      err   = pwrite;
    end else if (sel_st) begin
      rdata = {28'd0, rx_overrun, rx_valid, tx_pend, tx_busy};
    end else begin
      err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prdata  <= 32'd0;
      pslverr <= 1'b0;
      ctrl    <= 4'd0;
      baud    <= BAUD_RST;
    end else begin
      if (setup) begin
        prdata  <= rdata;
        pslverr <= err;
      end else if (!access) begin
        pslverr <= 1'b0;
      end
      if (wr_commit && sel_ctrl) ctrl <= pwdata[3:0];
      if (wr_commit && sel_baud) baud <= pwdata;
    end
  end

  assign txdata_wr   = wr_commit & sel_tx;
  assign txdata_byte = pwdata[7:0];
  assign rxdata_rd   = commit & ~pwrite & sel_rx;
  assign ovr_clr     = wr_commit & sel_st & pwdata[ST_RX_OVR];

endmodule

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB3 slave that configures and sequences one uart instance.
//
//   state  | meaning
//   T_IDLE | no frame in flight; starts one when TX_EN and a byte is pending
//   T_REQ  | uart_tx_enable high, waiting for uart_tx_done
//   T_REL  | uart_tx_enable low, waiting for uart_tx_done to drop
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   psel..pslverr                  APB3 slave, zero wait states
//   uart_data_in                   {3'b000, tx byte} presented to the uart
//   uart_baud_select               BAUD register
//   uart_tx_enable/uart_tx_done    TX request / completion handshake
//   uart_rx_enable/uart_rx_done    RX enable / completion pulse
//   uart_data_out                  received data, [7:0] used
//   irq                            level interrupt
module uart_apb_ctrl
  import uart_apb_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] BAUD_RST = 32'd868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [10:0]       uart_data_in,
  output logic [31:0]       uart_baud_select,
  output logic              uart_tx_enable,
  output logic              uart_rx_enable,
  input  logic [31:0]       uart_data_out,
  input  logic              uart_tx_done,
  input  logic              uart_rx_done,
  output logic              irq
);

  tx_state_t   state;
  logic [3:0]  ctrl;
  logic        tx_pend, tx_take, tx_busy, tx_en_r;
  logic [7:0]  hold_byte;
  logic        txdata_wr, rxdata_rd, ovr_clr;
  logic [7:0]  txdata_byte;
  logic        rx_done_q, rx_cap, rx_valid, rx_ovr;
  logic [7:0]  rx_byte;
  logic        unused_data_out;

  assign unused_data_out = ^uart_data_out[31:8];

  uart_apb_regs #(
    .ADDR_W   (ADDR_W),
    .BAUD_RST (BAUD_RST)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .tx_busy     (tx_busy),
    .tx_pend     (tx_pend),
    .tx_take     (tx_take),
    .rx_valid    (rx_valid),
    .rx_overrun  (rx_ovr),
    .rx_byte     (rx_byte),
    .ctrl        (ctrl),
    .baud        (uart_baud_select),
    .txdata_wr   (txdata_wr),
    .txdata_byte (txdata_byte),
    .rxdata_rd   (rxdata_rd),
    .ovr_clr     (ovr_clr)
  );

  assign tx_take = (state == T_IDLE) & ctrl[CTRL_TX_EN] & tx_pend;
  assign tx_busy = (state != T_IDLE);

  // Holding register; a write in the cycle it is consumed wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pend   <= 1'b0;
      hold_byte <= 8'd0;
    end else if (txdata_wr) begin
      tx_pend   <= 1'b1;
      hold_byte <= txdata_byte;
    end else if (tx_take) begin
      tx_pend   <= 1'b0;
    end
  end

  // T_REL is occupied for at least one cycle by construction, then waits
  // for the uart to release its done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= T_IDLE;
      tx_en_r      <= 1'b0;
      uart_data_in <= 11'd0;
    end else begin
      case (state)
        T_IDLE: if (tx_take) begin
          uart_data_in <= {3'b000, hold_byte};
          tx_en_r      <= 1'b1;
          state        <= T_REQ;
        end
        T_REQ: if (uart_tx_done) begin
          tx_en_r <= 1'b0;
          state   <= T_REL;
        end
        T_REL: if (!uart_tx_done) state <= T_IDLE;
        default: begin
          tx_en_r <= 1'b0;
          state   <= T_IDLE;
        end
      endcase
    end
  end

  // Reset gates the request combinationally so it drops in the reset cycle.
  assign uart_tx_enable = tx_en_r & ~rst;

  assign rx_cap = uart_rx_done & ~rx_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_rx_enable <= 1'b0;
      rx_done_q      <= 1'b0;
      rx_byte        <= 8'd0;
      rx_valid       <= 1'b0;
      rx_ovr         <= 1'b0;
      irq            <= 1'b0;
    end else begin
      uart_rx_enable <= ctrl[CTRL_RX_EN];
      rx_done_q      <= uart_rx_done;
      if (rx_cap) begin
        rx_byte  <= uart_data_out[7:0];
        rx_valid <= 1'b1;
      end else if (rxdata_rd) begin
        rx_valid <= 1'b0;
      end
      // A capture racing a read of the old byte is not an overrun.
      if (rx_cap && rx_valid && !rxdata_rd) rx_ovr <= 1'b1;
      else if (ovr_clr)                    rx_ovr <= 1'b0;
      irq <= (ctrl[CTRL_IE_TXE] & ~tx_pend) | (ctrl[CTRL_IE_RXV] & rx_valid);
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
module tb_uart_apb_ctrl;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [10:0]       uart_data_in;
  logic [31:0]       uart_baud_select;
  logic              uart_tx_enable, uart_rx_enable;
  logic [31:0]       uart_data_out = '0;
  logic              uart_tx_done = 1'b0;
  logic              uart_rx_done = 1'b0;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] sent_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] cur_baud = 32'd868;

  always #5 clk = ~clk;

  uart_apb_ctrl #(.ADDR_W(ADDR_W), .BAUD_RST(32'd868)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .uart_data_in(uart_data_in),
    .uart_baud_select(uart_baud_select), .uart_tx_enable(uart_tx_enable),
    .uart_rx_enable(uart_rx_enable), .uart_data_out(uart_data_out),
    .uart_tx_done(uart_tx_done), .uart_rx_done(uart_rx_done), .irq(irq)
  );

  // Behavioural uart transmitter: records each requested byte, raises done
  // after a random delay, releases it after the request drops.
  initial begin : responder
    forever begin
      @(posedge clk); #2;
      if (uart_tx_enable === 1'b1 && rst === 1'b0) begin
        sent_q.push_back(uart_data_in);
        repeat ($urandom_range(3, 6)) @(posedge clk);
        #2 uart_tx_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #2;
          if (uart_tx_enable !== 1'b1) break;
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #2 uart_tx_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr[ADDR_W-1:0]; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge clk); #1;
    uart_data_out = {$urandom_range(0, 255), $urandom_range(0, 65535), b};
    uart_rx_done = 1'b1;
    @(posedge clk); #1;
    uart_rx_done = 1'b0;
    uart_data_out = $urandom;
  endtask

  // Poll STATUS until the masked bits are clear; expiry is a failed comparison.
  task automatic wait_status_clear(input logic [31:0] mask, input string what);
    logic [31:0] rd; logic err; bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      apb(1'b0, 8'h10, 32'd0, rd, err);
      if ((rd & mask) == 32'd0) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: STATUS bits %0h still set, required clear", what, rd & mask);
    end
  endtask

  // Compare everything the uart was asked to send against the expected bytes.
  task automatic check_sent(input string what);
    n_cmp++;
    if (sent_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_count: sent %0d frames, required %0d", what, sent_q.size(), exp_q.size());
    end
    for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (sent_q[i] !== {3'b000, exp_q[i]}) begin
        n_err++;
        $display("FAIL %s_byte%0d: uart_data_in %03h, required %03h", what, i, sent_q[i], {3'b000, exp_q[i]});
      end
    end
    sent_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (uart_tx_enable !== 1'b0) begin n_err++; $display("FAIL reset_tx_enable: %0b, required 0", uart_tx_enable); end
    n_cmp++; if (uart_rx_enable !== 1'b0) begin n_err++; $display("FAIL reset_rx_enable: %0b, required 0", uart_rx_enable); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: %0b, required 0", irq); end
    n_cmp++; if (uart_data_in !== 11'd0) begin n_err++; $display("FAIL reset_data_in: %0h, required 0", uart_data_in); end
    n_cmp++; if (prdata !== 32'd0 || pslverr !== 1'b0 || pready !== 1'b1) begin
      n_err++; $display("FAIL reset_apb: prdata %0h pslverr %0b pready %0b, required 0/0/1", prdata, pslverr, pready); end
    n_cmp++; if (uart_baud_select !== 32'd868) begin n_err++; $display("FAIL reset_baud_out: %0d, required 868", uart_baud_select); end
    apb(1'b0, 8'h04, 0, rd, err);
    n_cmp++; if (rd !== 32'd868 || err !== 1'b0) begin n_err++; $display("FAIL reset_baud_rd: %0d err %0b, required 868 err 0", rd, err); end
    apb(1'b0, 8'h00, 0, rd, err);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_ctrl_rd: %0h, required 0", rd); end
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_status_rd: %0h, required 0", rd); end
  endtask

  task automatic test_tx_single();
    logic [31:0] rd; logic err; bit seen;
    logic [7:0] b;
    apb(1'b1, 8'h00, 32'h1, rd, err);
    apb(1'b1, 8'h08, 32'hFFFF_FFA5, rd, err);
    exp_q.push_back(8'hA5);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL tx_a5_wr: pslverr %0b, required 0", err); end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #3;
      if (uart_tx_done === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen || uart_tx_enable !== 1'b1) begin
      n_err++; $display("FAIL tx_a5_req: done seen %0b tx_enable %0b, required 1/1", seen, uart_tx_enable); end
    @(posedge clk); #1;
    n_cmp++; if (uart_tx_enable !== 1'b0) begin n_err++; $display("FAIL tx_a5_release: tx_enable %0b, required 0", uart_tx_enable); end
    n_cmp++; if (uart_data_in !== 11'h0A5) begin n_err++; $display("FAIL tx_a5_data: %03h, required 0A5", uart_data_in); end
    wait_status_clear(32'h3, "tx_a5_idle");
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      apb(1'b1, 8'h08, {24'($urandom), b}, rd, err);
      exp_q.push_back(b);
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL tx_rand_wr%0d: pslverr %0b, required 0", k, err); end
      apb(1'b0, 8'h10, 0, rd, err);
      n_cmp++; if (rd[1:0] == 2'b00) begin n_err++; $display("FAIL tx_rand_active%0d: STATUS %0h, required busy or pend", k, rd); end
      apb(1'b0, 8'h10, 0, rd, err);
      n_cmp++; if (rd[0] !== 1'b1) begin n_err++; $display("FAIL tx_rand_busy%0d: STATUS %0h, required tx_busy 1", k, rd); end
      wait_status_clear(32'h3, "tx_rand_idle");
    end
    check_sent("tx_single");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e1, e2, e3;
    logic [7:0] b1, b2, b3;
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    apb(1'b1, 8'h08, {24'd0, b1}, rd, e1);
    apb(1'b1, 8'h08, {24'd0, b2}, rd, e2);
    apb(1'b1, 8'h08, {24'd0, b3}, rd, e3);
    exp_q.push_back(b1); exp_q.push_back(b2);
    n_cmp++; if ({e1, e2, e3} !== 3'b001) begin
      n_err++; $display("FAIL b2b_pslverr: %b, required 001", {e1, e2, e3}); end
    wait_status_clear(32'h3, "b2b_idle");
    check_sent("b2b");
  endtask

  task automatic test_tx_stream();
    logic [31:0] rd; logic err;
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      wait_status_clear(32'h2, "stream_pend");
      b = 8'($urandom);
      apb(1'b1, 8'h08, {24'd0, b}, rd, err);
      exp_q.push_back(b);
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL stream_wr%0d: pslverr %0b, required 0", k, err); end
    end
    wait_status_clear(32'h3, "stream_idle");
    check_sent("stream");
    // With TX_EN low a pending byte waits; enabling releases it.
    apb(1'b1, 8'h00, 32'h0, rd, err);
    b = 8'($urandom);
    apb(1'b1, 8'h08, {24'd0, b}, rd, err);
    repeat (20) @(posedge clk);
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'h2 || sent_q.size() != 0) begin
      n_err++; $display("FAIL txen_off_hold: STATUS %0h frames %0d, required 2 and 0", rd, sent_q.size()); end
    apb(1'b1, 8'h00, 32'h1, rd, err);
    exp_q.push_back(b);
    wait_status_clear(32'h3, "txen_on_idle");
    check_sent("txen_on");
  endtask

  task automatic test_rx();
    logic [31:0] rd; logic err;
    logic [7:0] b;
    apb(1'b1, 8'h00, 32'h2, rd, err);
    @(posedge clk); #1;
    n_cmp++; if (uart_rx_enable !== 1'b1) begin n_err++; $display("FAIL rx_enable: %0b, required 1", uart_rx_enable); end
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      rx_pulse(b);
      apb(1'b0, 8'h10, 0, rd, err);
      n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL rx_valid%0d: STATUS %0h, required 4", k, rd); end
      apb(1'b0, 8'h0C, 0, rd, err);
      n_cmp++; if (rd !== {24'd0, b} || err !== 1'b0) begin
        n_err++; $display("FAIL rx_data%0d: %0h err %0b, required %0h err 0", k, rd, err, b); end
      apb(1'b0, 8'h10, 0, rd, err);
      n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rx_cleared%0d: STATUS %0h, required 0", k, rd); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd; logic err;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    rx_pulse(b1);
    repeat (2) @(posedge clk);
    rx_pulse(b2);
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'hC) begin n_err++; $display("FAIL ovr_status: %0h, required C", rd); end
    apb(1'b0, 8'h0C, 0, rd, err);
    n_cmp++; if (rd !== {24'd0, b2}) begin n_err++; $display("FAIL ovr_data: %0h, required %0h", rd, b2); end
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'h8) begin n_err++; $display("FAIL ovr_sticky: %0h, required 8", rd); end
    apb(1'b1, 8'h10, 32'h8, rd, err);
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ovr_w1c: %0h, required 0", rd); end
    // Capture landing in the commit cycle of an RXDATA read.
    rx_pulse(b1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h0C;
    @(posedge clk); #1;
    penable = 1'b1;
    uart_data_out = {24'd0, b2}; uart_rx_done = 1'b1;
    n_cmp++; if (prdata !== {24'd0, b1} || pslverr !== 1'b0) begin
      n_err++; $display("FAIL race_old_byte: %0h err %0b, required %0h err 0", prdata, pslverr, b1); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; uart_rx_done = 1'b0;
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL race_status: %0h, required 4", rd); end
    apb(1'b0, 8'h0C, 0, rd, err);
    n_cmp++; if (rd !== {24'd0, b2}) begin n_err++; $display("FAIL race_new_byte: %0h, required %0h", rd, b2); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err;
    apb(1'b1, 8'h00, 32'hA, rd, err);
    rx_pulse(8'($urandom));
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rxv_set: %0b, required 1", irq); end
    apb(1'b0, 8'h0C, 0, rd, err);
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_rxv_clr: %0b, required 0", irq); end
    apb(1'b1, 8'h00, 32'h4, rd, err);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_txe_set: %0b, required 1", irq); end
    apb(1'b1, 8'h08, 32'h5A, rd, err);
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_txe_clr: %0b, required 0", irq); end
    exp_q.push_back(8'h5A);
    apb(1'b1, 8'h00, 32'h1, rd, err);
    wait_status_clear(32'h3, "irq_flush");
    check_sent("irq_flush");
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err;
    logic [31:0] nb;
    nb = $urandom | 32'h1;
    apb(1'b1, 8'h04, nb, rd, err);
    cur_baud = nb;
    n_cmp++; if (err !== 1'b0 || uart_baud_select !== cur_baud) begin
      n_err++; $display("FAIL baud_wr: err %0b out %0h, required 0 %0h", err, uart_baud_select, cur_baud); end
    apb(1'b1, 8'h04, 32'd0, rd, err);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL baud_zero_err: %0b, required 1", err); end
    apb(1'b1, 8'h08, 32'h77, rd, err);
    exp_q.push_back(8'h77);
    apb(1'b1, 8'h04, nb ^ 32'h100, rd, err);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL baud_busy_err: %0b, required 1", err); end
    wait_status_clear(32'h3, "err_idle");
    check_sent("err_tx");
    apb(1'b0, 8'h04, 0, rd, err);
    n_cmp++; if (rd !== cur_baud) begin n_err++; $display("FAIL baud_kept: %0h, required %0h", rd, cur_baud); end
    apb(1'b1, 8'h14, $urandom, rd, err);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL unmapped_wr: err %0b, required 1", err); end
    apb(1'b0, 8'h1C, 0, rd, err);
    n_cmp++; if (err !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL unmapped_rd: %0h err %0b, required 0 err 1", rd, err); end
    apb(1'b1, 8'h0C, 32'h1, rd, err);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL rxdata_wr_err: %0b, required 1", err); end
    apb(1'b0, 8'h08, 0, rd, err);
    n_cmp++; if (err !== 1'b0 || rd !== 32'd0) begin n_err++; $display("FAIL txdata_rd: %0h err %0b, required 0 err 0", rd, err); end
    apb(1'b1, 8'h00, 32'hD, rd, err);
    apb(1'b0, 8'h00, 0, rd, err);
    n_cmp++; if (rd !== 32'hD) begin n_err++; $display("FAIL ctrl_rdback: %0h, required D", rd); end
  endtask

  task automatic test_midrst();
    logic [31:0] rd; logic err; bit seen;
    apb(1'b1, 8'h00, 32'h3, rd, err);
    apb(1'b1, 8'h08, 32'hC3, rd, err);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (uart_tx_enable === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL midrst_start: tx_enable 0, required 1"); end
    rst = 1'b1;
    #1;
    n_cmp++; if (uart_tx_enable !== 1'b0) begin n_err++; $display("FAIL midrst_drop: tx_enable %0b, required 0", uart_tx_enable); end
    @(posedge clk); #1;
    n_cmp++; if (uart_data_in !== 11'd0 || uart_baud_select !== 32'd868 || uart_rx_enable !== 1'b0) begin
      n_err++; $display("FAIL midrst_outs: data %0h baud %0d rx_en %0b, required 0 868 0",
                        uart_data_in, uart_baud_select, uart_rx_enable); end
    rst = 1'b0;
    apb(1'b0, 8'h00, 0, rd, err);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL midrst_ctrl: %0h, required 0", rd); end
    apb(1'b0, 8'h10, 0, rd, err);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL midrst_status: %0h, required 0", rd); end
    repeat (12) @(posedge clk);
    sent_q.delete();
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_tx_stream();
    test_rx();
    test_overrun();
    test_irq();
    test_errors();
    test_midrst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
